sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
// PURPOSE
//  Owns the single off-chip SRAM port and shares it between the VGA pixel-fetch path and one auxiliary requester.
//  The VGA path is the frame decoder's address encoder; the auxiliary requester is the sprite/mask loader with read and write.
//  During active video the VGA path owns the port unconditionally, with a fixed 2-cycle address->data latency.
//  Auxiliary reads and writes are scheduled round-robin in blanking, with bus turnaround handled here.
// PARAMETERS
//  ADDR_W   20  SRAM word address width
//  DATA_W   16  SRAM data width
// PORTS
//  i_clk          in   1       clock
//  i_rst_n        in   1       async active-low reset
//  i_vga_req      in   1       VGA pipeline issuing pixel addresses this cycle
//  i_vga_soon     in   1       high >=3 cycles before i_vga_req rises, until it rises
//  i_pix_addr     in   ADDR_W  VGA pixel fetch address
//  o_pix_data     out  DATA_W  SRAM word for i_pix_addr from 2 cycles earlier
//  i_rd_req       in   1       aux read request, level, held until o_rd_gnt
//  i_rd_addr      in   ADDR_W  aux read address, stable while i_rd_req
//  o_rd_gnt       out  1       1-cycle pulse: aux read address captured
//  o_rd_valid     out  1       1-cycle pulse, 1 cycle after o_rd_gnt
//  o_rd_data      out  DATA_W  aux read data, valid with o_rd_valid
//  i_wr_req       in   1       aux write request, level, held until o_wr_gnt
//  i_wr_addr      in   ADDR_W  aux write address
//  i_wr_data      in   DATA_W  aux write data
//  o_wr_gnt       out  1       1-cycle pulse: write address/data captured
//  o_sram_addr    out  ADDR_W  SRAM address pins
//  o_sram_wdata   out  DATA_W  data driven onto DQ when o_sram_dq_oe
//  o_sram_dq_oe   out  1       DQ tristate enable (1 = drive)
//  o_sram_we_n    out  1       SRAM write enable, active low
//  o_sram_oe_n    out  1       SRAM output enable, active low
//  i_sram_rdata   in   DATA_W  DQ input
// BEHAVIOUR
//  Reset values (async)
//   - state=IDLE; o_sram_we_n=1; o_sram_oe_n=1; o_sram_dq_oe=0.
//   - All addr/data outputs 0; all gnt/valid pulses 0; rr_last=WRITE, so read wins first.
//   - Reset mid-write drops we_n/dq_oe immediately.
//  States: IDLE, VGA, RD, WR_SETUP, WR_PULSE, TURN. All outputs registered.
//  Priority: VGA preempts at state boundaries. From any state except WR_SETUP/WR_PULSE:
//   - i_vga_req=1 -> VGA next.
//   - Aux grants are issued only when i_vga_req=0 and i_vga_soon=0.
//  VGA
//   - Each edge: o_sram_addr<=i_pix_addr; o_pix_data<=i_sram_rdata; oe_n=0.
//   - Result: data for address presented at cycle t appears on o_pix_data at t+2. No bubbles.
//   - i_vga_req=0 -> IDLE.
//  IDLE / RD: pick the aux requester with pending req.
//   - If both are pending, pick the one not in rr_last.
//   - Read: o_sram_addr<=i_rd_addr, o_rd_gnt<=1, oe_n=0 -> RD.
//   - Write: o_sram_addr<=i_wr_addr, o_sram_wdata<=i_wr_data, o_wr_gnt<=1, oe_n=1, dq_oe=1 -> WR_SETUP.
//  RD
//   - o_rd_data<=i_sram_rdata, o_rd_valid<=1.
//   - Back-to-back reads allowed: one read per cycle, arbitration applied again in the same cycle.
//  WR_SETUP -> WR_PULSE: we_n=0 for exactly 1 cycle, address/data held.
//  WR_PULSE -> TURN: we_n=1, data held 1 more cycle, then dq_oe=0 entering IDLE.
//   - A write is atomic (3 cycles); i_vga_soon guarantees it finishes before i_vga_req rises.
//   - If i_vga_req rises mid-write anyway, the write completes and o_pix_data is don't-care for those cycles.
//  Timing rules
//   - o_sram_dq_oe and o_sram_oe_n are never both active.
//   - The cycle after dq_oe falls has oe_n=1 (TURN).
//   - A grant pulse is never issued in the same cycle as another grant.
// TESTING
//  1. VGA stream: i_vga_req=1, i_pix_addr=0..9 one per cycle, SRAM model data=addr+0x100.
//     -> o_pix_data=0x100..0x109 starting 2 cycles after first addr, no gaps.
//  2. Aux read in blanking: i_rd_req, i_rd_addr=0x1234 (mem=0xBEEF).
//     -> o_rd_gnt next edge, o_rd_valid+o_rd_data=0xBEEF one cycle later, then IDLE.
//  3. Aux write: i_wr_req addr=0x00042 data=0xA5A5.
//     -> we_n low exactly 1 cycle with addr/data stable; dq_oe drops after TURN.
//     -> A subsequent read of 0x00042 returns 0xA5A5.
//  4. Round-robin: rd and wr held high together in blanking.
//     -> grants alternate R,W,R,W starting with read.
//     -> dq_oe and oe_n never overlap.
//  5. Blocking: i_vga_soon=1 while i_rd_req=1 -> no o_rd_gnt until i_vga_req falls.
//     -> VGA latency still exactly 2 cycles after handover.
//  6. Reset during WR_PULSE: assert i_rst_n=0.
//     -> we_n=1, dq_oe=0, oe_n=1 immediately; state IDLE, no gnt/valid after release.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// Single-port SRAM arbiter. During active video the VGA pixel fetch owns the port.
// In blanking, auxiliary reads and writes share the port round-robin, and this block handles the DQ turnaround.
module sram_access_arbiter #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vga_req,
    input  logic              i_vga_soon,
    input  logic [ADDR_W-1:0] i_pix_addr,
    output logic [DATA_W-1:0] o_pix_data,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_gnt,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_gnt,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_dq_oe,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    input  logic [DATA_W-1:0] i_sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VGA,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_TURN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rr_last_wr;
    logic              rr_last_wr_nxt;

    logic [ADDR_W-1:0] sram_addr_nxt;
    logic [DATA_W-1:0] sram_wdata_nxt;
    logic [DATA_W-1:0] pix_data_nxt;
    logic [DATA_W-1:0] rd_data_nxt;
    logic              rd_gnt_nxt;
    logic              rd_valid_nxt;
    logic              wr_gnt_nxt;
    logic              dq_oe_nxt;
    logic              we_n_nxt;
    logic              oe_n_nxt;

    logic              aux_ok_c;
    logic              pick_rd_c;
    logic              pick_wr_c;

    // Aux arbitration: only in blanking with no video imminent; ties go to whoever was not served last.
    always_comb begin
        aux_ok_c  = !i_vga_req && !i_vga_soon;
        pick_rd_c = aux_ok_c && i_rd_req && (!i_wr_req || rr_last_wr);
        pick_wr_c = aux_ok_c && i_wr_req && (!i_rd_req || !rr_last_wr);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        rr_last_wr_nxt = rr_last_wr;
        sram_addr_nxt  = o_sram_addr;
        sram_wdata_nxt = o_sram_wdata;
        pix_data_nxt   = o_pix_data;
        rd_data_nxt    = o_rd_data;
        rd_gnt_nxt     = 1'b0;
        rd_valid_nxt   = 1'b0;
        wr_gnt_nxt     = 1'b0;
        dq_oe_nxt      = 1'b0;
        we_n_nxt       = 1'b1;
        oe_n_nxt       = 1'b1;

        case (state)
            S_WR_SETUP: begin
                state_nxt = S_WR_PULSE;
                dq_oe_nxt = 1'b1;
                we_n_nxt  = 1'b0;
            end
            S_WR_PULSE: begin
                // Strobe released but data kept on DQ one more cycle for hold time.
                state_nxt = S_TURN;
                dq_oe_nxt = 1'b1;
            end
            default: begin
                if (state == S_VGA) begin
                    pix_data_nxt = i_sram_rdata;
                end
                if (state == S_RD) begin
                    rd_data_nxt  = i_sram_rdata;
                    rd_valid_nxt = 1'b1;
                end

                if (i_vga_req) begin
                    state_nxt     = S_VGA;
                    sram_addr_nxt = i_pix_addr;
                    oe_n_nxt      = 1'b0;
                end else if ((state == S_IDLE || state == S_RD) && pick_rd_c) begin
                    state_nxt      = S_RD;
                    rr_last_wr_nxt = 1'b0;
                    sram_addr_nxt  = i_rd_addr;
                    rd_gnt_nxt     = 1'b1;
                    oe_n_nxt       = 1'b0;
                end else if ((state == S_IDLE || state == S_RD) && pick_wr_c) begin
                    state_nxt      = S_WR_SETUP;
                    rr_last_wr_nxt = 1'b1;
                    sram_addr_nxt  = i_wr_addr;
                    sram_wdata_nxt = i_wr_data;
                    wr_gnt_nxt     = 1'b1;
                    dq_oe_nxt      = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // State and registered outputs. Reset releases the bus immediately, even mid-write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            rr_last_wr   <= 1'b1;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_pix_data   <= '0;
            o_rd_data    <= '0;
            o_rd_gnt     <= 1'b0;
            o_rd_valid   <= 1'b0;
            o_wr_gnt     <= 1'b0;
            o_sram_dq_oe <= 1'b0;
            o_sram_we_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
        end else begin
            state        <= state_nxt;
            rr_last_wr   <= rr_last_wr_nxt;
            o_sram_addr  <= sram_addr_nxt;
            o_sram_wdata <= sram_wdata_nxt;
            o_pix_data   <= pix_data_nxt;
            o_rd_data    <= rd_data_nxt;
            o_rd_gnt     <= rd_gnt_nxt;
            o_rd_valid   <= rd_valid_nxt;
            o_wr_gnt     <= wr_gnt_nxt;
            o_sram_dq_oe <= dq_oe_nxt;
            o_sram_we_n  <= we_n_nxt;
            o_sram_oe_n  <= oe_n_nxt;
        end
    end

    // Bus invariants: no DQ contention, a single grant per cycle, and a write strobe only while DQ is driven.
    a_no_contention: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_sram_dq_oe && !o_sram_oe_n));
    a_one_grant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_rd_gnt && o_wr_gnt));
    a_we_with_dq: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(!o_sram_we_n && !o_sram_dq_oe));

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: directed scenarios plus a randomized mix, checked against a word-level memory model.
module tb_sram_access_arbiter;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              vga_req;
    logic              vga_soon;
    logic [ADDR_W-1:0] pix_addr;
    logic [DATA_W-1:0] pix_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_dq_oe;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic [DATA_W-1:0] sram_rdata;

    int tests = 0;
    int fails = 0;
    int inv_viol = 0;

    sram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_vga_req    (vga_req),
        .i_vga_soon   (vga_soon),
        .i_pix_addr   (pix_addr),
        .o_pix_data   (pix_data),
        .i_rd_req     (rd_req),
        .i_rd_addr    (rd_addr),
        .o_rd_gnt     (rd_gnt),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .i_wr_req     (wr_req),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_wr_gnt     (wr_gnt),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .o_sram_dq_oe (sram_dq_oe),
        .o_sram_we_n  (sram_we_n),
        .o_sram_oe_n  (sram_oe_n),
        .i_sram_rdata (sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous SRAM device model: preset contents, writes land while WE# is low.
    logic [DATA_W-1:0] sram_mem [0:65535];
    logic              mem_ready = 1'b0;

    assign sram_rdata = sram_oe_n ? 16'hDEAD : sram_mem[sram_addr[15:0]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) sram_mem[i] <= 16'(i + 32'h100);
            sram_mem[16'h1234] <= 16'hBEEF;
            mem_ready <= 1'b1;
        end else if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr[15:0]] <= sram_wdata;
        end
    end

    // Reference contents: the preset rule plus every write the bench has had granted.
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        if (a == 20'h01234) return 16'hBEEF;
        return 16'(a[15:0] + 16'h0100);
    endfunction

    // Bus-protocol watcher, summarised into the check count at the end of each phase.
    logic prev_dq = 1'b0;
    logic prev_we_low = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (sram_dq_oe && !sram_oe_n) inv_viol++;
            if (rd_gnt && wr_gnt) inv_viol++;
            if (!sram_we_n && (prev_we_low || !sram_dq_oe)) inv_viol++;
            if (prev_dq && !sram_dq_oe && !sram_oe_n) inv_viol++;
        end
        prev_dq     <= sram_dq_oe;
        prev_we_low <= !sram_we_n;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no completion, expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aux_read(input logic [ADDR_W-1:0] a);
        bit got;
        rd_req  = 1'b1;
        rd_addr = a;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rd_gnt) begin
                got = 1'b1;
                break;
            end
        end
        rd_req = 1'b0;
        check("rd_gnt_seen", 32'(got), 32'd1);
        check("rd_addr_pins", 32'(sram_addr), 32'(a));
        check("rd_oe_n", 32'({sram_oe_n, sram_dq_oe}), 32'b00);
        tick();
        check("rd_valid", 32'({rd_valid, rd_gnt}), 32'b10);
        check("rd_data", 32'(rd_data), 32'(ref_rd(a)));
        tick();
        check("rd_valid_pulse", 32'(rd_valid), 32'd0);
    endtask

    task automatic aux_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit got;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (wr_gnt) begin
                got = 1'b1;
                break;
            end
        end
        wr_req = 1'b0;
        check("wr_gnt_seen", 32'(got), 32'd1);
        ref_mem[a] = d;
        check("wr_setup_ctl", 32'({sram_dq_oe, sram_oe_n, sram_we_n}), 32'b111);
        check("wr_setup_addr", 32'(sram_addr), 32'(a));
        check("wr_setup_data", 32'(sram_wdata), 32'(d));
        tick();
        check("wr_pulse_ctl", 32'({sram_dq_oe, sram_oe_n, sram_we_n, wr_gnt}), 32'b1100);
        check("wr_pulse_addr", 32'(sram_addr), 32'(a));
        check("wr_pulse_data", 32'(sram_wdata), 32'(d));
        tick();
        check("wr_turn_ctl", 32'({sram_dq_oe, sram_oe_n, sram_we_n}), 32'b111);
        check("wr_turn_data", 32'(sram_wdata), 32'(d));
        tick();
        check("wr_done_ctl", 32'({sram_dq_oe, sram_oe_n, sram_we_n}), 32'b011);
    endtask

    // Stream n pixel addresses; each word must appear two cycles after its address.
    task automatic vga_burst(input int n, input bit rnd);
        logic [ADDR_W-1:0] a [$];
        vga_req  = 1'b1;
        vga_soon = 1'b0;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                pix_addr = rnd ? 20'($urandom_range(0, 127)) : 20'(i);
                a.push_back(pix_addr);
            end else begin
                vga_req = 1'b0;
            end
            tick();
            if (i < n) check("vga_addr", 32'(sram_addr), 32'(a[i]));
            if (i >= 1) check("vga_pix", 32'(pix_data), 32'(ref_rd(a[i-1])));
            check("vga_no_aux_gnt", 32'({rd_gnt, wr_gnt}), 32'd0);
        end
    endtask

    initial begin
        int  n_gnt;
        bit  exp_rd;
        bit  pend;
        logic [DATA_W-1:0] pend_data;

        rst_n = 1'b1;
        vga_req = 1'b0; vga_soon = 1'b0; pix_addr = '0;
        rd_req = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_ctl", 32'({sram_we_n, sram_oe_n, sram_dq_oe}), 32'b110);
        check("rst_pulses", 32'({rd_gnt, wr_gnt, rd_valid}), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_data", 32'({pix_data, rd_data, sram_wdata}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_ctl", 32'({sram_we_n, sram_oe_n, sram_dq_oe}), 32'b110);

        // Sequential VGA stream 0..9.
        vga_burst(10, 1'b0);
        check("vga_end_oe", 32'(sram_oe_n), 32'd1);

        // Aux read in blanking.
        aux_read(20'h01234);

        // Aux write followed by read-back.
        aux_write(20'h00042, 16'hA5A5);
        aux_read(20'h00042);
        check("inv_basic", 32'(inv_viol), 32'd0);

        // Read held off by vga_soon, then served after the video burst.
        vga_soon = 1'b1;
        rd_req   = 1'b1;
        rd_addr  = 20'h00300;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("soon_blocks_gnt", 32'({rd_gnt, wr_gnt}), 32'd0);
        end
        vga_burst(6, 1'b1);
        aux_read(20'h00300);

        // Reset while WE# is low.
        wr_req  = 1'b1;
        wr_addr = 20'h00F00;
        wr_data = 16'h1357;
        tick();
        check("rw_gnt", 32'(wr_gnt), 32'd1);
        wr_req = 1'b0;
        tick();
        check("rw_pulse", 32'(sram_we_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rw_rst_ctl", 32'({sram_we_n, sram_dq_oe, sram_oe_n}), 32'b101);
        tick(); tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rw_post_pulses", 32'({rd_gnt, wr_gnt, rd_valid}), 32'd0);
            check("rw_post_ctl", 32'({sram_we_n, sram_dq_oe, sram_oe_n}), 32'b101);
        end
        check("inv_mid", 32'(inv_viol), 32'd0);

        // Round-robin with both requesters held: R, W, R, W ... from reset.
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        rd_addr = 20'($urandom_range(0, 31));
        wr_addr = 20'($urandom_range(0, 31));
        wr_data = 16'($urandom);
        exp_rd = 1'b1;
        n_gnt = 0;
        pend = 1'b0;
        pend_data = '0;
        for (int k = 0; k < 80 && n_gnt < 8; k++) begin
            tick();
            if (pend) begin
                check("rr_rd_valid", 32'(rd_valid), 32'd1);
                check("rr_rd_data", 32'(rd_data), 32'(pend_data));
                pend = 1'b0;
            end
            if (rd_gnt || wr_gnt) begin
                check("rr_kind", 32'(rd_gnt), 32'(exp_rd));
                if (rd_gnt) begin
                    pend = 1'b1;
                    pend_data = ref_rd(rd_addr);
                    rd_addr = 20'($urandom_range(0, 31));
                end else begin
                    ref_mem[wr_addr] = wr_data;
                    wr_addr = 20'($urandom_range(0, 31));
                    wr_data = 16'($urandom);
                end
                exp_rd = !rd_gnt;
                n_gnt++;
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        check("rr_grant_count", 32'(n_gnt), 32'd8);
        tick();
        if (pend) begin
            check("rr_rd_valid_last", 32'(rd_valid), 32'd1);
            check("rr_rd_data_last", 32'(rd_data), 32'(pend_data));
        end
        repeat (4) tick();
        check("inv_rr", 32'(inv_viol), 32'd0);

        // Randomized mix of reads, writes and video bursts.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: aux_read(20'($urandom_range(0, 63)));
                1: aux_write(20'($urandom_range(0, 63)), 16'($urandom));
                default: vga_burst(int'($urandom_range(2, 8)), 1'b1);
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end
        check("inv_final", 32'(inv_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
